// File: rtl/init_sequencer_if.sv
// -----------------------------------------------------------------------------
// init_sequencer_if
//   Bundle of the signals exchanged between the init sequencer and the three
//   downstream stages it brings out of reset.
//
//   Signals
//     stage_ready [2:0]  stage -> sequencer  bit k: stage k finished its init
//     retry              stage -> sequencer  single-cycle restart request
//     rst_stage   [2:0]  sequencer -> stage  bit k: active-high reset of stage k
//     init_done          sequencer -> stage  all stages released and ready
//     init_fail          sequencer -> stage  sequencer sits in FAIL
//     fail_stage  [1:0]  sequencer -> stage  stage that caused the last failure
//
//   Modports
//     master : the sequencer (drives the resets and status)
//     slave  : the downstream side / environment
// -----------------------------------------------------------------------------
interface init_sequencer_if;
    logic [2:0] stage_ready;
    logic       retry;
    logic [2:0] rst_stage;
    logic       init_done;
    logic       init_fail;
    logic [1:0] fail_stage;

    modport master (
        input  stage_ready,
        input  retry,
        output rst_stage,
        output init_done,
        output init_fail,
        output fail_stage
    );

    modport slave (
        output stage_ready,
        output retry,
        input  rst_stage,
        input  init_done,
        input  init_fail,
        input  fail_stage
    );
endinterface

// File: rtl/init_sequencer.sv
// -----------------------------------------------------------------------------
// init_sequencer
//   Releases three downstream stages from reset strictly in the order 0, 1, 2.
//   After global reset all stage resets are held for HOLD_CYCLES cycles, then
//   stage 0 is released; each further stage is released one cycle after the
//   previous one reports ready. A stage that stays silent for TIMEOUT_CYCLES
//   cycles sends the sequencer to FAIL, where a retry pulse restarts the hold.
//
//   Parameters
//     HOLD_CYCLES    (1..65535) cycles all stage resets stay asserted
//     TIMEOUT_CYCLES (1..65535) cycles allowed for a released stage to go ready
//
//   Ports
//     clock  : system clock, rising edge
//     reset  : synchronous, active-high global reset
//     bus    : init_sequencer_if.master (stage_ready, retry in;
//              rst_stage, init_done, init_fail, fail_stage out)
//
//   Build option
//     INIT_SEQ_WATCHDOG_EN : when defined, a stage dropping its ready flag in
//                            DONE sends the sequencer to FAIL. When undefined,
//                            stage_ready is ignored in DONE.
//
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module init_sequencer #(
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clock,
    input  logic              reset,
    init_sequencer_if.master  bus
);

    localparam logic [2:0] ST_HOLD  = 3'd0;
    localparam logic [2:0] ST_WAIT0 = 3'd1;
    localparam logic [2:0] ST_WAIT1 = 3'd2;
    localparam logic [2:0] ST_WAIT2 = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_FAIL  = 3'd5;

    localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    logic [15:0] hold_cnt;
    logic [15:0] tmo_cnt;
    logic [2:0]  rst_stage_q;
    logic        init_done_q;
    logic        init_fail_q;
    logic [1:0]  fail_stage_q;

    // Per-WAIT-state decode: which stage is awaited, where a ready flag leads,
    // and the stage-reset pattern that goes with that next state.
    logic [1:0] wait_idx;
    logic [2:0] ready_next;
    logic [2:0] ready_rst;

    // Counters saturate instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        wait_idx   = 2'd0;
        ready_next = ST_DONE;
        ready_rst  = 3'b000;
        case (state)
            ST_WAIT0: begin
                wait_idx   = 2'd0;
                ready_next = ST_WAIT1;
                ready_rst  = 3'b100;
            end
            ST_WAIT1: begin
                wait_idx   = 2'd1;
                ready_next = ST_WAIT2;
                ready_rst  = 3'b000;
            end
            ST_WAIT2: begin
                wait_idx   = 2'd2;
                ready_next = ST_DONE;
                ready_rst  = 3'b000;
            end
            default: ;
        endcase
    end

`ifdef INIT_SEQ_WATCHDOG_EN
    // Lowest-numbered stage whose ready flag has dropped.
    logic [1:0] lowest_low;
    always_comb begin
        if (!bus.stage_ready[0])      lowest_low = 2'd0;
        else if (!bus.stage_ready[1]) lowest_low = 2'd1;
        else                          lowest_low = 2'd2;
    end
`endif

    // NOTE: non-blocking assignments for all state so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            // Reset wins over retry and over any state; hold counter stays 0
            // so the hold period only begins once reset is released.
            state        <= ST_HOLD;
            hold_cnt     <= 16'd0;
            tmo_cnt      <= 16'd0;
            rst_stage_q  <= 3'b111;
            init_done_q  <= 1'b0;
            init_fail_q  <= 1'b0;
            fail_stage_q <= 2'd0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= ST_WAIT0;
                        rst_stage_q <= 3'b110;
                        tmo_cnt     <= 16'd0;
                    end else begin
                        hold_cnt <= sat_inc(hold_cnt);
                    end
                end

                ST_WAIT0, ST_WAIT1, ST_WAIT2: begin
                    // Ready is checked first so it beats a same-cycle timeout.
                    if (bus.stage_ready[wait_idx]) begin
                        state       <= ready_next;
                        rst_stage_q <= ready_rst;
                        init_done_q <= (ready_next == ST_DONE);
                        tmo_cnt     <= 16'd0;
                    end else if (tmo_cnt == TIMEOUT_LAST) begin
                        state        <= ST_FAIL;
                        rst_stage_q  <= 3'b111;
                        init_fail_q  <= 1'b1;
                        fail_stage_q <= wait_idx;
                    end else begin
                        tmo_cnt <= sat_inc(tmo_cnt);
                    end
                end

                ST_DONE: begin
`ifdef INIT_SEQ_WATCHDOG_EN
                    if (!(&bus.stage_ready)) begin
                        state        <= ST_FAIL;
                        rst_stage_q  <= 3'b111;
                        init_done_q  <= 1'b0;
                        init_fail_q  <= 1'b1;
                        fail_stage_q <= lowest_low;
                    end
`endif
                end

                ST_FAIL: begin
                    // fail_stage is deliberately kept for post-mortem reads.
                    if (bus.retry) begin
                        state       <= ST_HOLD;
                        hold_cnt    <= 16'd0;
                        init_fail_q <= 1'b0;
                    end
                end

                default: begin
                    state       <= ST_HOLD;
                    hold_cnt    <= 16'd0;
                    rst_stage_q <= 3'b111;
                    init_done_q <= 1'b0;
                    init_fail_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rst_stage  = rst_stage_q;
    assign bus.init_done  = init_done_q;
    assign bus.init_fail  = init_fail_q;
    assign bus.fail_stage = fail_stage_q;

endmodule

// File: tb/tb_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_init_sequencer
//   Drives init_sequencer (HOLD_CYCLES=4, TIMEOUT_CYCLES=10) with directed
//   scenarios followed by randomized stage behaviour, and compares every
//   output after every edge with a behavioural model of the release sequence.
// -----------------------------------------------------------------------------
module tb_init_sequencer;

    localparam int HOLD    = 4;
    localparam int TIMEOUT = 10;

    logic clock;
    logic reset;

    init_sequencer_if bus ();

    init_sequencer #(
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: which phase of the bring-up we are in, which stage
    // is awaited and how long we have been there.
    // ------------------------------------------------------------------
    typedef enum {M_HOLD, M_WAIT, M_DONE, M_FAIL} mode_t;

    mode_t m_mode   = M_HOLD;
    int    m_k      = 0;   // stage being waited on
    int    m_cnt    = 0;   // cycles spent in current hold / wait
    int    m_fstage = 0;

    // Stages 0..k are out of reset while waiting on stage k.
    function automatic int exp_rst();
        case (m_mode)
            M_WAIT:  return (7 << (m_k + 1)) & 7;
            M_DONE:  return 0;
            default: return 7;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic [2:0] sr, input logic rt);
        if (r) begin
            m_mode = M_HOLD; m_cnt = 0; m_fstage = 0;
        end else begin
            case (m_mode)
                M_HOLD: begin
                    if (m_cnt == HOLD - 1) begin
                        m_mode = M_WAIT; m_k = 0; m_cnt = 0;
                    end else m_cnt++;
                end
                M_WAIT: begin
                    if (sr[m_k]) begin
                        if (m_k == 2) m_mode = M_DONE;
                        else m_k++;
                        m_cnt = 0;
                    end else if (m_cnt == TIMEOUT - 1) begin
                        m_mode = M_FAIL; m_fstage = m_k;
                    end else m_cnt++;
                end
                M_DONE: begin
`ifdef INIT_SEQ_WATCHDOG_EN
                    if (sr != 3'b111) begin
                        m_mode = M_FAIL;
                        for (int i = 2; i >= 0; i--) if (!sr[i]) m_fstage = i;
                    end
`endif
                end
                M_FAIL: begin
                    if (rt) begin m_mode = M_HOLD; m_cnt = 0; end
                end
            endcase
        end
    endtask

    // ------------------------------------------------------------------
    // Stage behaviour: a released stage goes ready dly[k] cycles after
    // its reset falls.
    // ------------------------------------------------------------------
    int since [3] = '{0, 0, 0};
    int dly   [3] = '{2, 2, 2};

    function automatic logic [2:0] auto_ready(input bit noise);
        logic [2:0] sr;
        int rs;
        rs = exp_rst();
        for (int k = 0; k < 3; k++) begin
            if (rs[k] == 1'b0) sr[k] = (since[k] >= dly[k]);
            else               sr[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        return sr;
    endfunction

    task automatic cycle(input logic r, input logic [2:0] sr, input logic rt);
        int rs;
        reset           = r;
        bus.stage_ready = sr;
        bus.retry       = rt;
        model_step(r, sr, rt);
        @(posedge clock);
        #1;
        check("rst_stage",  bus.rst_stage,  exp_rst());
        check("init_done",  bus.init_done,  (m_mode == M_DONE) ? 1 : 0);
        check("init_fail",  bus.init_fail,  (m_mode == M_FAIL) ? 1 : 0);
        check("fail_stage", bus.fail_stage, m_fstage);
        rs = exp_rst();
        for (int k = 0; k < 3; k++) since[k] = (rs[k] == 1'b0) ? since[k] + 1 : 0;
    endtask

    task automatic auto_run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, auto_ready(1'b0), 1'b0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.stage_ready = 3'b000;
        bus.retry       = 1'b0;

        // Nominal bring-up: reset 3 cycles, each stage ready 2 cycles later.
        dly = '{2, 2, 2};
        repeat (3) cycle(1'b1, 3'b000, 1'b0);
        check("reset_rst_stage", bus.rst_stage, 3'b111);
        auto_run(25);
        check("nominal_done", bus.init_done, 1'b1);

        // Retry outside FAIL is ignored.
        cycle(1'b0, 3'b111, 1'b1);
        check("retry_in_done", bus.init_done, 1'b1);

        // DONE with a stage dropping its ready flag.
        cycle(1'b0, 3'b101, 1'b0);
`ifdef INIT_SEQ_WATCHDOG_EN
        check("wdog_fail",  bus.init_fail,  1'b1);
        check("wdog_stage", bus.fail_stage, 2'd1);
`else
        check("wdog_off_done", bus.init_done, 1'b1);
`endif

        // Reset while waiting on stage 2, then a full repeat.
        dly = '{1, 1, 50};
        cycle(1'b1, 3'b000, 1'b0);
        auto_run(10);
        check("in_wait2", bus.rst_stage, 3'b000);
        cycle(1'b1, 3'b000, 1'b0);
        check("reset_in_wait2", bus.rst_stage, 3'b111);
        dly = '{2, 2, 2};
        auto_run(25);
        check("repeat_done", bus.init_done, 1'b1);

        // Stage 1 never ready -> timeout.
        dly = '{1, 50, 50};
        cycle(1'b1, 3'b000, 1'b0);
        auto_run(20);
        check("timeout_fail",  bus.init_fail,  1'b1);
        check("timeout_stage", bus.fail_stage, 2'd1);

        // Retry together with reset: reset wins and clears fail_stage.
        cycle(1'b1, 3'b000, 1'b1);
        check("rst_retry_stage", bus.fail_stage, 2'd0);
        auto_run(20);

        // Retry in FAIL: hold restarts, stage 0 released 4 cycles later.
        cycle(1'b0, 3'b000, 1'b1);
        check("retry_keeps_stage", bus.fail_stage, 2'd1);
        repeat (HOLD - 1) cycle(1'b0, 3'b000, 1'b0);
        check("retry_hold_rst", bus.rst_stage, 3'b111);
        cycle(1'b0, 3'b000, 1'b0);
        check("retry_release0", bus.rst_stage, 3'b110);

        // Ready on the last allowed cycle of WAIT0 beats the timeout.
        cycle(1'b1, 3'b000, 1'b0);
        repeat (HOLD) cycle(1'b0, 3'b000, 1'b0);
        repeat (TIMEOUT - 1) cycle(1'b0, 3'b000, 1'b0);
        cycle(1'b0, 3'b001, 1'b0);
        check("ready_wins_fail", bus.init_fail, 1'b0);
        check("ready_wins_rst",  bus.rst_stage, 3'b100);

        // Randomized stage timing, noise on unreleased bits, retries, resets.
        cycle(1'b1, 3'b000, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       rt;
            logic [2:0] sr;
            r  = ($urandom_range(0, 199) == 0);
            rt = ($urandom_range(0, 7) == 0);
            sr = auto_ready(1'b1);
            if (m_mode == M_DONE && $urandom_range(0, 19) == 0)
                sr[$urandom_range(0, 2)] = 1'b0;
            if (r || (m_mode == M_FAIL && rt))
                for (int k = 0; k < 3; k++) dly[k] = $urandom_range(0, 12);
            cycle(r, sr, rt);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
